// File: rtl/seven_seg_led.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// A free-running refresh counter picks one hex nibble at a time. The nibble is
// decoded onto shared active-low segment lines, and its active-low anode is
// enabled. Every output is registered, so the display follows the counter by
// one clock.
module seven_seg_led #(
   parameter int CNT_WIDTH = 18
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] in0,
   input  logic [3:0] in1,
   input  logic [3:0] in2,
   input  logic [3:0] in3,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       d,
   output logic       e,
   output logic       f,
   output logic       g,
   output logic       dp,
   output logic [3:0] an
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic [CNT_WIDTH-1:0] cnt;
   logic [1:0]           idx;
   logic [3:0]           nibble;
   logic [6:0]           seg_dec;
   logic [3:0]           an_dec;
   logic [6:0]           seg_q;
   logic [3:0]           an_q;
   logic                 dp_q;

   // The digit slot comes from the counter value before it is incremented.
   // This is the value the registers capture on the same edge.
   assign idx = cnt[CNT_WIDTH-1 -: 2];

   // Select the nibble of the active digit. The other digits' inputs are ignored.
   always_comb begin
      nibble = in0;
      unique case (idx)
         2'd0: nibble = in0;
         2'd1: nibble = in1;
         2'd2: nibble = in2;
         2'd3: nibble = in3;
      endcase
   end

   // One anode line is low: the line of the active digit.
   always_comb begin
      an_dec = ~(4'b0001 << idx);
   end

   // Hex-to-segment decode, active-low {a,b,c,d,e,f,g}.
   always_comb begin
      seg_dec = 7'b1111111;
      unique case (nibble)
         4'h0: seg_dec = 7'b0000001;
         4'h1: seg_dec = 7'b1001111;
         4'h2: seg_dec = 7'b0010010;
         4'h3: seg_dec = 7'b0000110;
         4'h4: seg_dec = 7'b1001100;
         4'h5: seg_dec = 7'b0100100;
         4'h6: seg_dec = 7'b0100000;
         4'h7: seg_dec = 7'b0001111;
         4'h8: seg_dec = 7'b0000000;
         4'h9: seg_dec = 7'b0000100;
         4'hA: seg_dec = 7'b0001000;
         4'hB: seg_dec = 7'b1100000;
         4'hC: seg_dec = 7'b0110001;
         4'hD: seg_dec = 7'b1000010;
         4'hE: seg_dec = 7'b0110000;
         4'hF: seg_dec = 7'b0111000;
      endcase
   end

   // Refresh counter and output registers. Reset blanks the display and
   // restarts the scan at digit 0.
   always_ff @(posedge clock) begin
      if (!reset) begin
         cnt   <= '0;
         an_q  <= 4'b1111;
         seg_q <= 7'b1111111;
         dp_q  <= 1'b1;
      end else begin
         cnt   <= cnt + CNT_ONE;
         an_q  <= an_dec;
         seg_q <= seg_dec;
         dp_q  <= 1'b1;
      end
   end

   assign {a, b, c, d, e, f, g} = seg_q;
   assign dp                    = dp_q;
   assign an                    = an_q;

endmodule

// File: tb/tb_seven_seg_led.sv
// Bench for seven_seg_led with a 4-bit refresh counter (4 cycles per digit).
module tb_seven_seg_led;

   localparam int W        = 4;
   localparam int SLOT     = 1 << (W - 2);
   localparam int CNT_MOD  = 1 << W;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
   logic       a, b, c, d, e, f, g, dp;
   logic [3:0] an;

   int checks = 0;
   int errors = 0;

   // Segment patterns from the display's character table, indexed by value.
   logic [6:0] dec_tab [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   seven_seg_led #(.CNT_WIDTH(W)) dut (
      .clock(clock), .reset(reset),
      .in0(in0), .in1(in1), .in2(in2), .in3(in3),
      .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
      .dp(dp), .an(an));

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // The reference model counts the elapsed run edges and looks up the digit and its decode.
   int         m_edges = 0;
   logic [3:0] m_an    = 4'b1111;
   logic [6:0] m_seg   = 7'b1111111;
   bit         m_valid = 0;

   always @(posedge clock) begin
      logic [3:0] digits [4];
      int         slot;
      digits = '{in0, in1, in2, in3};
      if (!reset) begin
         m_edges = 0;
         m_an    = 4'b1111;
         m_seg   = 7'b1111111;
      end else begin
         slot    = (m_edges % CNT_MOD) / SLOT;
         m_an    = 4'b1111;
         m_an[slot] = 1'b0;
         m_seg   = dec_tab[digits[slot]];
         m_edges = m_edges + 1;
      end
      m_valid = 1;
   end

   // On every cycle, compare the DUT outputs with the model.
   always @(negedge clock) begin
      if (m_valid) begin
         check("model_an",  {12'd0, an}, {12'd0, m_an});
         check("model_seg", {9'd0, a, b, c, d, e, f, g}, {9'd0, m_seg});
         check("model_dp",  {15'd0, dp}, 16'd1);
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clock);
   endtask

   function automatic logic [15:0] seg_now();
      return {9'd0, a, b, c, d, e, f, g};
   endfunction

   task automatic restart();
      reset = 1'b0;
      step(1);
      reset = 1'b1;
   endtask

   logic [3:0] an_lit  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
   logic [6:0] seg1234 [4] = '{7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100};

   initial begin
      // Hold reset for two edges.
      reset = 1'b0; in0 = 4'hF;
      step(2);
      check("reset_an",  {12'd0, an}, 16'h000F);
      check("reset_seg", seg_now(), 16'h007F);
      check("reset_dp",  {15'd0, dp}, 16'd1);

      // Release reset. Digit 0 shows F, then digit 1 shows 0.
      reset = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         step(1);
         if (i <= 4) begin
            check("rel_an_d0",  {12'd0, an}, 16'h000E);
            check("rel_seg_d0", seg_now(), {9'd0, 7'b0111000});
         end else begin
            check("rel_an_d1",  {12'd0, an}, 16'h000D);
            check("rel_seg_d1", seg_now(), {9'd0, 7'b0000001});
         end
      end

      // Digits show 1, 2, 3 and 4 over two full scans.
      restart();
      in0 = 4'h1; in1 = 4'h2; in2 = 4'h3; in3 = 4'h4;
      for (int i = 0; i < 32; i++) begin
         step(1);
         check("scan_an",  {12'd0, an}, {12'd0, an_lit[(i / 4) % 4]});
         check("scan_seg", seg_now(), {9'd0, seg1234[(i / 4) % 4]});
      end

      // Change in0 on every edge while digit 0 is selected.
      for (int v = 0; v < 16; v++) begin
         if (v % 4 == 0) restart();
         in0 = v[3:0];
         step(1);
         check("sweep_an",  {12'd0, an}, 16'h000E);
         check("sweep_seg", seg_now(), {9'd0, dec_tab[v]});
      end

      // Assert reset while digit 2 is shown, then release it.
      restart();
      step(9);
      check("mid_an_d2", {12'd0, an}, 16'h000B);
      reset = 1'b0;
      step(1);
      check("mid_rst_an",  {12'd0, an}, 16'h000F);
      check("mid_rst_seg", seg_now(), 16'h007F);
      reset = 1'b1;
      step(1);
      check("mid_restart_an", {12'd0, an}, 16'h000E);

      // Change in3 while digit 0 is selected. The new value appears only in the slot of digit 3.
      restart();
      in0 = 4'h5; in1 = 4'h6; in2 = 4'h7; in3 = 4'h8;
      step(1);
      in3 = 4'hA;
      step(11);
      check("late_an_d2",  {12'd0, an}, 16'h000B);
      check("late_seg_d2", seg_now(), {9'd0, 7'b0001111});
      step(1);
      check("late_an_d3",  {12'd0, an}, 16'h0007);
      check("late_seg_d3", seg_now(), {9'd0, 7'b0001000});

      // Random inputs with occasional resets, checked against the model.
      for (int i = 0; i < 400; i++) begin
         in0   = 4'($urandom_range(15));
         in1   = 4'($urandom_range(15));
         in2   = 4'($urandom_range(15));
         in3   = 4'($urandom_range(15));
         reset = ($urandom_range(24) == 0) ? 1'b0 : 1'b1;
         step(1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
